// File: rtl/interval_timer_if.sv
// Register-strobe bus between the Avalon register adapter and the interval timer.
// The adapter (master) drives one-hot per-register strobes and write data; the
// timer (slave) returns one 32-bit word per register plus a level interrupt.
interface interval_timer_if #(
    parameter int REGS = 4
);
    logic [REGS-1:0]       write_en;
    logic [REGS-1:0]       read_en;
    logic [31:0]           data_in;
    logic [REGS-1:0][31:0] data_out;
    logic                  irq;

    modport master (
        output write_en,
        output read_en,
        output data_in,
        input  data_out,
        input  irq
    );

    modport slave (
        input  write_en,
        input  read_en,
        input  data_in,
        output data_out,
        output irq
    );
endinterface

// File: rtl/interval_timer.sv
// Memory-mapped down-counting interval timer.
// Register map: 0 CTRL, 1 LOAD, 2 COUNT (read-only snapshot), 3 STATUS.
// A prescaled tick decrements the count; reaching the end of the count is an
// expiry that either reloads from LOAD or stops the timer (one-shot). Expiries
// set a sticky flag that drives a registered level interrupt; expiries that
// land while the flag is still set are tallied in a saturating missed counter.
module interval_timer #(
    parameter int REGS           = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    interval_timer_if.slave bus
);
    localparam int REG_CTRL   = 0;
    localparam int REG_LOAD   = 1;
    localparam int REG_COUNT  = 2;
    localparam int REG_STATUS = 3;
    localparam int PW         = PRESCALE_WIDTH;

    localparam logic [7:0] MISSED_MAX = 8'hFF;

    // Strobe decode
    logic [REGS-1:0] wr_strobe;
    logic [REGS-1:0] rd_strobe;
    logic            wr_ctrl;
    logic            wr_load;
    logic            wr_status;
    logic            rd_count;
    logic            clr_expired;
    logic            clr_missed;
    logic            unused_strobes;

    // CTRL register
    logic            ctrl_enable;
    logic            ctrl_auto_reload;
    logic            ctrl_irq_en;
    logic [PW-1:0]   ctrl_prescale;
    logic            ctrl_enable_d;
    logic            ctrl_auto_reload_d;
    logic            ctrl_irq_en_d;
    logic [PW-1:0]   ctrl_prescale_d;

    // Counting datapath
    logic [31:0]     load_q;
    logic [31:0]     load_d;
    logic [31:0]     count_q;
    logic [31:0]     count_d;
    logic [31:0]     snapshot_q;
    logic [31:0]     snapshot_d;
    logic [PW-1:0]   prescale_cnt;
    logic [PW-1:0]   prescale_cnt_d;
    logic            tick;
    logic            expiry;

    // STATUS and interrupt
    logic            expired_q;
    logic            expired_d;
    logic [7:0]      missed_q;
    logic [7:0]      missed_d;
    logic            irq_q;
    logic            irq_d;

    assign wr_strobe = bus.write_en;
    assign rd_strobe = bus.read_en;

    // Only the COUNT read strobe has a side effect; the other reads are pure
    // register outputs and the COUNT write strobe is deliberately ignored.
    assign unused_strobes = ^{rd_strobe[REG_CTRL], rd_strobe[REG_LOAD],
                              rd_strobe[REG_STATUS], wr_strobe[REG_COUNT]};

    // Per-register strobe decode and STATUS write-one-to-clear bits
    always_comb begin
        wr_ctrl     = wr_strobe[REG_CTRL];
        wr_load     = wr_strobe[REG_LOAD];
        wr_status   = wr_strobe[REG_STATUS];
        rd_count    = rd_strobe[REG_COUNT];
        clr_expired = wr_status && bus.data_in[0];
        clr_missed  = wr_status && bus.data_in[1];
    end

    // Tick and expiry detection; a LOAD write suppresses the expiry of its cycle
    always_comb begin
        tick   = ctrl_enable && (prescale_cnt == ctrl_prescale);
        expiry = tick && !wr_load && (count_q <= 32'd1);
    end

    // CTRL next state: a write replaces the register, a one-shot expiry stops it
    always_comb begin
        ctrl_enable_d      = ctrl_enable;
        ctrl_auto_reload_d = ctrl_auto_reload;
        ctrl_irq_en_d      = ctrl_irq_en;
        ctrl_prescale_d    = ctrl_prescale;
        if (wr_ctrl) begin
            ctrl_enable_d      = bus.data_in[0];
            ctrl_auto_reload_d = bus.data_in[1];
            ctrl_irq_en_d      = bus.data_in[2];
            ctrl_prescale_d    = bus.data_in[8 +: PW];
        end else if (expiry && !ctrl_auto_reload) begin
            ctrl_enable_d = 1'b0;
        end
    end

    // Prescale counter: runs 0..prescale while enabled, parked at 0 otherwise.
    // Being parked at 0 while disabled is what makes a 0->1 enable start clean.
    // If prescale is lowered below the running count, the counter wraps
    // through its full range before ticking again rather than stalling.
    always_comb begin
        prescale_cnt_d = prescale_cnt + PW'(1);
        if (wr_load || !ctrl_enable || !ctrl_enable_d || tick) begin
            prescale_cnt_d = '0;
        end
    end

    // Count, LOAD and snapshot next state; a LOAD write wins over a tick
    always_comb begin
        load_d     = load_q;
        count_d    = count_q;
        snapshot_d = snapshot_q;
        if (wr_load) begin
            load_d  = bus.data_in;
            count_d = bus.data_in;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_auto_reload) begin
                count_d = load_q;
            end else begin
                count_d = 32'd0;
            end
        end
        if (rd_count) begin
            snapshot_d = count_q;
        end
    end

    // STATUS next state: an expiry beats a same-cycle clear of expired, and
    // such a collision is not counted as a missed expiry
    always_comb begin
        expired_d = expired_q;
        missed_d  = missed_q;
        if (expiry) begin
            expired_d = 1'b1;
        end else if (clr_expired) begin
            expired_d = 1'b0;
        end
        if (clr_missed) begin
            missed_d = 8'd0;
        end else if (expiry && expired_q && !clr_expired && (missed_q != MISSED_MAX)) begin
            missed_d = missed_q + 8'd1;
        end
        irq_d = expired_q && ctrl_irq_en;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_prescale    <= '0;
            load_q           <= 32'd0;
            count_q          <= 32'd0;
            snapshot_q       <= 32'd0;
            prescale_cnt     <= '0;
            expired_q        <= 1'b0;
            missed_q         <= 8'd0;
            irq_q            <= 1'b0;
        end else begin
            ctrl_enable      <= ctrl_enable_d;
            ctrl_auto_reload <= ctrl_auto_reload_d;
            ctrl_irq_en      <= ctrl_irq_en_d;
            ctrl_prescale    <= ctrl_prescale_d;
            load_q           <= load_d;
            count_q          <= count_d;
            snapshot_q       <= snapshot_d;
            prescale_cnt     <= prescale_cnt_d;
            expired_q        <= expired_d;
            missed_q         <= missed_d;
            irq_q            <= irq_d;
        end
    end

    // Register read words, straight from flops
    always_comb begin
        bus.data_out[REG_CTRL]   = {{(32 - 8 - PW){1'b0}}, ctrl_prescale, 5'b0,
                                    ctrl_irq_en, ctrl_auto_reload, ctrl_enable};
        bus.data_out[REG_LOAD]   = load_q;
        bus.data_out[REG_COUNT]  = snapshot_q;
        bus.data_out[REG_STATUS] = {16'b0, missed_q, 6'b0, ctrl_enable, expired_q};
        bus.irq                  = irq_q;
    end
endmodule
